mc_unit_issue: RTL and testbench

// Initiator side of the start/busy handshake used by the multi-cycle execute units (CLZ, MUL, DIV).
// - Accepts one decoded multi-cycle op from the ID/EX stage.
// - Pulses start to the selected unit, stalls the pipeline until the unit's busy falls, then writes back the result once (GPR rd or HI/LO).
// - Sits between the decoder/pipeline control and the unit bank.

---
 rtl/mc_unit_issue_pkg.sv | 22 ++
 rtl/mc_unit_issue_if.sv | 27 ++
 rtl/mc_unit_issue_timeout_cnt.sv | 42 ++++
 rtl/mc_unit_issue.sv | 192 +++++++++++++++++++
 tb/tb_mc_unit_issue.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_unit_issue_pkg.sv
// Shared definitions for the multi-cycle unit issue block: FSM state encoding,
// unit indices, bus widths and the default WAIT timeout.
package mc_pkg;

    localparam int unsigned MC_N_UNITS = 3;
    localparam int unsigned MC_TIMEOUT = 64;
    localparam int unsigned UNIT_IDX_W = 2;
    localparam int unsigned GPR_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;

    localparam logic [UNIT_IDX_W-1:0] UNIT_CLZ = 2'd0;
    localparam logic [UNIT_IDX_W-1:0] UNIT_MUL = 2'd1;
    localparam logic [UNIT_IDX_W-1:0] UNIT_DIV = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } mc_state_e;

endpackage

// File: rtl/mc_unit_issue_if.sv
// Start/busy handshake bundle between the issuer and the multi-cycle unit bank.
//   unit_start  : one-hot start pulse, issuer -> units
//   unit_busy   : per-unit busy, units -> issuer
//   unit_res_lo : per-unit result low word (CLZ count lives here)
//   unit_res_hi : per-unit result high word
interface mc_unit_issue_if #(
    parameter int unsigned N_UNITS = 3
);
    logic [N_UNITS-1:0]       unit_start;
    logic [N_UNITS-1:0]       unit_busy;
    logic [N_UNITS-1:0][31:0] unit_res_lo;
    logic [N_UNITS-1:0][31:0] unit_res_hi;

    modport master (
        output unit_start,
        input  unit_busy,
        input  unit_res_lo,
        input  unit_res_hi
    );

    modport slave (
        input  unit_start,
        output unit_busy,
        output unit_res_lo,
        output unit_res_hi
    );
endinterface

// File: rtl/mc_unit_issue_timeout_cnt.sv
// WAIT-state cycle counter.
//   clk, reset : clock, synchronous active-high reset
//   clr        : force count to zero (takes priority over en)
//   en         : advance count by one
//   first_c    : count is zero (first WAIT cycle)
//   term_c     : count has reached TERM-1
module mc_timeout_cnt #(
    parameter int unsigned TERM = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic first_c,
    output logic term_c
);
    localparam int unsigned CNT_W = $clog2(TERM);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign first_c = (cnt_q == '0);
    assign term_c  = (cnt_q == CNT_W'(TERM - 1));

    // Saturate at the terminal count so the compare stays asserted.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !term_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mc_unit_issue.sv
// Initiator for the multi-cycle execute units (CLZ/MUL/DIV). Accepts one op,
// pulses start to the selected unit, stalls the pipeline until busy falls and
// writes the result back exactly once (GPR rd or HI/LO).
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/unit/dest/hilo : decoded multi-cycle op from EX
//   ub                  : unit bank handshake (start, busy, results)
//   stall               : combinational pipeline freeze
//   wb_en/wb_addr/wb_data : GPR writeback
//   hilo_we/hi_data/lo_data : HI/LO writeback
//   err_timeout, err_proto : sticky error flags
//   err_illegal         : single-cycle pulse on an out-of-range unit index
module mc_unit_issue
    import mc_pkg::*;
#(
    parameter int unsigned N_UNITS     = MC_N_UNITS,
    parameter int unsigned TIMEOUT_CYC = MC_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [UNIT_IDX_W-1:0] req_unit,
    input  logic [GPR_ADDR_W-1:0] req_dest,
    input  logic                  req_hilo,
    mc_unit_issue_if.master       ub,
    output logic                  stall,
    output logic                  wb_en,
    output logic [GPR_ADDR_W-1:0] wb_addr,
    output logic [XLEN-1:0]       wb_data,
    output logic                  hilo_we,
    output logic [XLEN-1:0]       hi_data,
    output logic [XLEN-1:0]       lo_data,
    output logic                  err_timeout,
    output logic                  err_proto,
    output logic                  err_illegal
);
    mc_state_e             state_q, state_d;
    logic [UNIT_IDX_W-1:0] unit_q, unit_d;
    logic [GPR_ADDR_W-1:0] dest_q, dest_d;
    logic                  hilo_q, hilo_d;
    logic [N_UNITS-1:0]    unit_start_q, unit_start_d;
    logic                  wb_en_q, wb_en_d;
    logic [GPR_ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]       wb_data_q, wb_data_d;
    logic                  hilo_we_q, hilo_we_d;
    logic [XLEN-1:0]       hi_data_q, hi_data_d;
    logic [XLEN-1:0]       lo_data_q, lo_data_d;
    logic                  err_timeout_q, err_timeout_d;
    logic                  err_proto_q, err_proto_d;
    logic                  err_illegal_q, err_illegal_d;

    logic                  req_legal;
    logic                  cnt_clr, cnt_en;
    logic                  cnt_first_c, cnt_term_c;
    logic                  sel_busy;
    logic [XLEN-1:0]       sel_lo, sel_hi;

    mc_timeout_cnt #(
        .TERM (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .first_c (cnt_first_c),
        .term_c  (cnt_term_c)
    );

    // Result/busy select from the latched unit index.
    assign sel_busy = ub.unit_busy[unit_q];
    assign sel_lo   = ub.unit_res_lo[unit_q];
    assign sel_hi   = ub.unit_res_hi[unit_q];

    assign req_legal = req_valid && (32'(req_unit) < N_UNITS);

    // Next-state, stall and registered-output next values.
    always_comb begin
        state_d       = state_q;
        unit_d        = unit_q;
        dest_d        = dest_q;
        hilo_d        = hilo_q;
        unit_start_d  = '0;
        wb_en_d       = 1'b0;
        wb_addr_d     = wb_addr_q;
        wb_data_d     = wb_data_q;
        hilo_we_d     = 1'b0;
        hi_data_d     = hi_data_q;
        lo_data_d     = lo_data_q;
        err_timeout_d = err_timeout_q;
        err_proto_d   = err_proto_q;
        err_illegal_d = 1'b0;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;
        stall         = 1'b0;

        case (state_q)
            IDLE: begin
                stall = req_legal;
                if (req_legal) begin
                    unit_d       = req_unit;
                    dest_d       = req_dest;
                    hilo_d       = req_hilo;
                    unit_start_d = N_UNITS'(1) << req_unit;
                    state_d      = ISSUE;
                end else if (req_valid) begin
                    err_illegal_d = 1'b1;
                end
            end
            ISSUE: begin
                stall   = 1'b1;
                cnt_clr = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                stall  = 1'b1;
                cnt_en = 1'b1;
                if (!sel_busy) begin
                    // A unit that never went busy did not see the start.
                    if (cnt_first_c) begin
                        err_proto_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        if (hilo_q) begin
                            hi_data_d = sel_hi;
                            lo_data_d = sel_lo;
                            hilo_we_d = 1'b1;
                        end else begin
                            wb_data_d = sel_lo;
                            wb_addr_d = dest_q;
                            wb_en_d   = (dest_q != '0);
                        end
                        state_d = DONE;
                    end
                end else if (cnt_term_c) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            DONE: begin
                // Any req_valid here is the retiring op; do not re-accept it.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            unit_q        <= '0;
            dest_q        <= '0;
            hilo_q        <= 1'b0;
            unit_start_q  <= '0;
            wb_en_q       <= 1'b0;
            wb_addr_q     <= '0;
            wb_data_q     <= '0;
            hilo_we_q     <= 1'b0;
            hi_data_q     <= '0;
            lo_data_q     <= '0;
            err_timeout_q <= 1'b0;
            err_proto_q   <= 1'b0;
            err_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            unit_q        <= unit_d;
            dest_q        <= dest_d;
            hilo_q        <= hilo_d;
            unit_start_q  <= unit_start_d;
            wb_en_q       <= wb_en_d;
            wb_addr_q     <= wb_addr_d;
            wb_data_q     <= wb_data_d;
            hilo_we_q     <= hilo_we_d;
            hi_data_q     <= hi_data_d;
            lo_data_q     <= lo_data_d;
            err_timeout_q <= err_timeout_d;
            err_proto_q   <= err_proto_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    assign ub.unit_start = unit_start_q;
    assign wb_en         = wb_en_q;
    assign wb_addr       = wb_addr_q;
    assign wb_data       = wb_data_q;
    assign hilo_we       = hilo_we_q;
    assign hi_data       = hi_data_q;
    assign lo_data       = lo_data_q;
    assign err_timeout   = err_timeout_q;
    assign err_proto     = err_proto_q;
    assign err_illegal   = err_illegal_q;
endmodule

// File: tb/tb_mc_unit_issue.sv
// Self-checking bench for mc_unit_issue: table of single ops plus hand-written
// sequences for timeout, protocol error, illegal unit and mid-WAIT reset.
module tb_mc_unit_issue;
    import mc_pkg::*;

    localparam int unsigned N = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [1:0]  req_unit;
    logic [4:0]  req_dest;
    logic        req_hilo;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        hilo_we;
    logic [31:0] hi_data;
    logic [31:0] lo_data;
    logic        err_timeout;
    logic        err_proto;
    logic        err_illegal;

    mc_unit_issue_if #(.N_UNITS(N)) ub ();

    mc_unit_issue #(.N_UNITS(N), .TIMEOUT_CYC(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_unit    (req_unit),
        .req_dest    (req_dest),
        .req_hilo    (req_hilo),
        .ub          (ub),
        .stall       (stall),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .hilo_we     (hilo_we),
        .hi_data     (hi_data),
        .lo_data     (lo_data),
        .err_timeout (err_timeout),
        .err_proto   (err_proto),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    // ---------------- unit bank model ----------------
    int          cfg_len [N];
    logic [31:0] cfg_lo  [N];
    logic [31:0] cfg_hi  [N];
    logic        cfg_ignore [N];
    logic [31:0] cfg_op;
    int          m_cnt [N];
    logic [31:0] m_lo  [N];
    logic [31:0] m_hi  [N];

    function automatic int clz32(input logic [31:0] x);
        int  n;
        bit  found;
        n = 0;
        found = 0;
        for (int i = 31; i >= 0; i--) begin
            if (x[i]) found = 1;
            if (!found) n++;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                m_cnt[i] <= 0;
                m_lo[i]  <= '0;
                m_hi[i]  <= '0;
            end else if (ub.unit_start[i] && !cfg_ignore[i]) begin
                if (i == 0) begin
                    m_cnt[i] <= clz32(cfg_op) + 1;
                    m_lo[i]  <= 32'(clz32(cfg_op));
                    m_hi[i]  <= '0;
                end else begin
                    m_cnt[i] <= cfg_len[i];
                    m_lo[i]  <= cfg_lo[i];
                    m_hi[i]  <= cfg_hi[i];
                end
            end else if (m_cnt[i] > 0) begin
                m_cnt[i] <= m_cnt[i] - 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ub.unit_busy[i]   = (m_cnt[i] != 0);
            ub.unit_res_lo[i] = m_lo[i];
            ub.unit_res_hi[i] = m_hi[i];
        end
    end

    // ---------------- checking ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic [1:0]  unit;
        logic [4:0]  dest;
        logic        hilo;
        logic [31:0] op;
        logic [31:0] res_hi;
        logic [31:0] res_lo;
        int          len;
        int          exp_waits;
        logic        exp_wb_en;
        logic        exp_hilo_we;
        logic [31:0] exp_wb_data;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs [8];

    // Count WAIT cycles (stall high after ISSUE); flag any strobe/start seen meanwhile.
    task automatic wait_ops(output int waits, output bit junk);
        bit done;
        waits = 0;
        junk  = 0;
        done  = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (!stall) done = 1;
            else begin
                waits++;
                if (ub.unit_start != 3'b000 || wb_en || hilo_we) junk = 1;
            end
        end
        if (!done) waits = 999;
    endtask

    // Issue at the drive point (just after a rising edge, DUT in IDLE).
    task automatic issue(input logic [1:0] u, input logic [4:0] d, input logic h);
        logic [2:0] oh;
        oh = 3'b001 << u;
        req_valid = 1'b1;
        req_unit  = u;
        req_dest  = d;
        req_hilo  = h;
        @(negedge clk);
        check("stall_on_accept", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("start_pulse", 32'(ub.unit_start), 32'(oh));
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int waits;
        bit junk;
        if (v.unit == UNIT_CLZ) cfg_op = v.op;
        else begin
            cfg_len[v.unit] = v.len;
            cfg_lo[v.unit]  = v.res_lo;
            cfg_hi[v.unit]  = v.res_hi;
        end
        issue(v.unit, v.dest, v.hilo);
        wait_ops(waits, junk);
        check($sformatf("v%0d_wait_cycles", idx), 32'(waits), 32'(v.exp_waits));
        check($sformatf("v%0d_quiet_in_wait", idx), 32'(junk), 32'd0);
        check($sformatf("v%0d_wb_en", idx), 32'(wb_en), 32'(v.exp_wb_en));
        if (v.exp_wb_en) check($sformatf("v%0d_wb_addr", idx), 32'(wb_addr), 32'(v.dest));
        check($sformatf("v%0d_wb_data", idx), wb_data, v.exp_wb_data);
        check($sformatf("v%0d_hilo_we", idx), 32'(hilo_we), 32'(v.exp_hilo_we));
        check($sformatf("v%0d_hi", idx), hi_data, v.exp_hi);
        check($sformatf("v%0d_lo", idx), lo_data, v.exp_lo);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("v%0d_strobes_drop", idx), 32'({wb_en, hilo_we}), 32'd0);
        check($sformatf("v%0d_wb_data_hold", idx), wb_data, v.exp_wb_data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  waits;
        bit  junk;

        //        unit      dest  hilo op            res_hi        res_lo        len waits wb  hl  wb_data        hi            lo
        vecs[0] = '{UNIT_CLZ, 5'd8,  1'b0, 32'h00010000, 32'h0,        32'h0,        0,  17,  1'b1, 1'b0, 32'd15,       32'h0,        32'h0};
        vecs[1] = '{UNIT_CLZ, 5'd3,  1'b0, 32'h80000000, 32'h0,        32'h0,        0,  2,   1'b1, 1'b0, 32'd0,        32'h0,        32'h0};
        vecs[2] = '{UNIT_CLZ, 5'd5,  1'b0, 32'h00000000, 32'h0,        32'h0,        0,  34,  1'b1, 1'b0, 32'd32,       32'h0,        32'h0};
        vecs[3] = '{UNIT_MUL, 5'd9,  1'b1, 32'h0,        32'h00000001, 32'hFFFFFFFE, 4,  5,   1'b0, 1'b1, 32'd32,       32'h00000001, 32'hFFFFFFFE};
        vecs[4] = '{UNIT_DIV, 5'd17, 1'b0, 32'h0,        32'h0000AAAA, 32'h12345678, 2,  3,   1'b1, 1'b0, 32'h12345678, 32'h00000001, 32'hFFFFFFFE};
        vecs[5] = '{UNIT_DIV, 5'd0,  1'b1, 32'h0,        32'hDEAD0001, 32'h0000BEEF, 3,  4,   1'b0, 1'b1, 32'h12345678, 32'hDEAD0001, 32'h0000BEEF};
        vecs[6] = '{UNIT_CLZ, 5'd1,  1'b0, 32'h40000000, 32'h0,        32'h0,        0,  3,   1'b1, 1'b0, 32'd1,        32'hDEAD0001, 32'h0000BEEF};
        vecs[7] = '{UNIT_CLZ, 5'd0,  1'b0, 32'h000000FF, 32'h0,        32'h0,        0,  26,  1'b0, 1'b0, 32'd24,       32'h0,        32'h0};

        for (int i = 0; i < N; i++) begin
            cfg_len[i] = 1; cfg_lo[i] = '0; cfg_hi[i] = '0; cfg_ignore[i] = 1'b0;
        end
        cfg_op    = '0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_unit  = '0;
        req_dest  = '0;
        req_hilo  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_outputs", 32'({stall, wb_en, hilo_we, err_timeout, err_proto, err_illegal, ub.unit_start}), 32'd0);
        check("reset_data", wb_data | hi_data | lo_data | 32'(wb_addr), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_op(vecs[i], i);

        // Timeout: MUL stays busy well past 64 WAIT cycles.
        cfg_len[1] = 100;
        cfg_lo[1]  = 32'h5555AAAA;
        cfg_hi[1]  = 32'h11112222;
        issue(UNIT_MUL, 5'd4, 1'b1);
        wait_ops(waits, junk);
        check("timeout_wait_cycles", 32'(waits), 32'd64);
        check("timeout_no_strobe", 32'({junk, wb_en, hilo_we}), 32'd0);
        check("timeout_flag", 32'(err_timeout), 32'd1);
        check("timeout_hilo_kept", hi_data ^ lo_data, 32'hDEAD0001 ^ 32'h0000BEEF);
        @(posedge clk);
        #1;
        run_op(vecs[6], 6);
        check("timeout_sticky", 32'(err_timeout), 32'd1);

        // Protocol error: DIV never raises busy.
        cfg_ignore[2] = 1'b1;
        issue(UNIT_DIV, 5'd7, 1'b0);
        check("proto_not_yet", 32'(err_proto), 32'd0);
        wait_ops(waits, junk);
        check("proto_wait_cycles", 32'(waits), 32'd1);
        check("proto_flag", 32'(err_proto), 32'd1);
        check("proto_no_strobe", 32'({junk, wb_en, hilo_we}), 32'd0);
        check("proto_wb_data_kept", wb_data, 32'd1);
        cfg_ignore[2] = 1'b0;
        @(posedge clk);
        #1;

        // Illegal unit index.
        req_valid = 1'b1;
        req_unit  = 2'd3;
        req_dest  = 5'd6;
        @(negedge clk);
        check("illegal_no_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("illegal_pulse", 32'(err_illegal), 32'd1);
        check("illegal_no_start", 32'({stall, ub.unit_start}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("illegal_pulse_end", 32'(err_illegal), 32'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a long CLZ WAIT.
        cfg_op = 32'h0;
        issue(UNIT_CLZ, 5'd12, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midreset_ctrl", 32'({stall, wb_en, hilo_we, err_timeout, err_proto, err_illegal, ub.unit_start}), 32'd0);
        check("midreset_data", wb_data | hi_data | lo_data | 32'(wb_addr), 32'd0);
        @(posedge clk);
        #1;
        run_op(vecs[7], 7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
